// File: rtl/core_pkg.sv
// Shared register-file write-back types and constants.
package core_pkg;

    localparam int unsigned ADD_WIDTH  = 5;
    localparam int unsigned DATA_WIDTH = 32;
    localparam logic [ADD_WIDTH-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [ADD_WIDTH-1:0]  rd;
        logic [DATA_WIDTH-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        NORMAL = 1'b0,
        DRAIN  = 1'b1
    } wb_state_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding LSU write-back results until a write slot frees up.
module wb_fifo
    import core_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter type entry_t = wb_entry_t
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  entry_t                       push_data,
    input  logic                         pop,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output entry_t                       head
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push_ok;
    logic               pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Pointer and occupancy update; pointers wrap at DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an empty count makes every entry dead
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/regfile_writer.sv
// Single register-file writer: merges ALU and LSU results, one write per cycle,
// with an LSU FIFO and a drain mode that stalls the ALU when the LSU is starved.
module regfile_writer
    import core_pkg::*;
#(
    parameter int unsigned add_width    = ADD_WIDTH,
    parameter int unsigned data_width   = DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [add_width-1:0]  alu_rd,
    input  logic [data_width-1:0] alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [add_width-1:0]  lsu_rd,
    input  logic [data_width-1:0] lsu_data,
    output logic                  regwrite,
    output logic [add_width-1:0]  add_rd,
    output logic [data_width-1:0] write_data,
    output logic                  busy
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [add_width-1:0]  rd;
        logic [data_width-1:0] data;
    } entry_t;

    wb_state_t              state_q, state_d;
    logic [STV_W-1:0]       starve_q, starve_d;
    logic                   regwrite_q, regwrite_d;
    logic [add_width-1:0]   add_rd_q, add_rd_d;
    logic [data_width-1:0]  write_data_q, write_data_d;

    logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0]       fifo_count;
    entry_t                 fifo_head, lsu_entry;
    logic                   alu_wr, lsu_wr, lsu_cut;

    assign alu_ready  = (state_q == NORMAL);
    assign lsu_ready  = !fifo_full;
    assign busy       = !fifo_empty || (state_q == DRAIN);
    assign regwrite   = regwrite_q;
    assign add_rd     = add_rd_q;
    assign write_data = write_data_q;

    // Accepted transfers to x0 are swallowed here
    assign alu_wr    = alu_valid && alu_ready && (alu_rd != add_width'(REG_ZERO));
    assign lsu_wr    = lsu_valid && lsu_ready && (lsu_rd != add_width'(REG_ZERO));
    assign lsu_entry = '{rd: lsu_rd, data: lsu_data};

    wb_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (lsu_entry),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    // Write-slot arbitration, starvation counter and drain FSM
    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        regwrite_d   = 1'b0;
        add_rd_d     = add_rd_q;
        write_data_d = write_data_q;
        fifo_push    = 1'b0;
        fifo_pop     = 1'b0;
        lsu_cut      = 1'b0;

        if (state_q == NORMAL) begin
            if (alu_wr) begin
                regwrite_d   = 1'b1;
                add_rd_d     = alu_rd;
                write_data_d = alu_data;
            end else if (!fifo_empty) begin
                fifo_pop     = 1'b1;
                regwrite_d   = 1'b1;
                add_rd_d     = fifo_head.rd;
                write_data_d = fifo_head.data;
            end else if (lsu_wr) begin
                lsu_cut      = 1'b1;
                regwrite_d   = 1'b1;
                add_rd_d     = lsu_rd;
                write_data_d = lsu_data;
            end
            fifo_push = lsu_wr && !lsu_cut;

            if (fifo_empty || fifo_pop) begin
                starve_d = '0;
            end else if (alu_wr && (starve_q != STV_W'(STARVE_LIMIT))) begin
                starve_d = starve_q + STV_W'(1);
            end
            if (starve_d == STV_W'(STARVE_LIMIT)) begin
                state_d = DRAIN;
            end
        end else begin
            fifo_pop  = !fifo_empty;
            fifo_push = lsu_wr;
            starve_d  = '0;
            if (fifo_pop) begin
                regwrite_d   = 1'b1;
                add_rd_d     = fifo_head.rd;
                write_data_d = fifo_head.data;
            end
            if (fifo_empty || ((fifo_count == CNT_W'(1)) && !fifo_push)) begin
                state_d = NORMAL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= NORMAL;
            starve_q     <= '0;
            regwrite_q   <= 1'b0;
            add_rd_q     <= '0;
            write_data_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            regwrite_q   <= regwrite_d;
            add_rd_q     <= add_rd_d;
            write_data_q <= write_data_d;
        end
    end

endmodule

// File: tb/tb_regfile_writer.sv
// Directed bench for regfile_writer: each task drives one scenario and checks hand-computed results.
module tb_regfile_writer;

    logic        clk;
    logic        rst_n;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        regwrite;
    logic [4:0]  add_rd;
    logic [31:0] write_data;
    logic        busy;

    int pass_cnt = 0;
    int total_cnt = 0;

    regfile_writer #(
        .add_width    (5),
        .data_width   (32),
        .FIFO_DEPTH   (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_rd     (lsu_rd),
        .lsu_data   (lsu_data),
        .regwrite   (regwrite),
        .add_rd     (add_rd),
        .write_data (write_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        alu_valid = v; alu_rd = rd; alu_data = d;
    endtask

    task automatic drive_lsu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        lsu_valid = v; lsu_rd = rd; lsu_data = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_alu(1'b0, 5'd0, 32'h0);
        drive_lsu(1'b0, 5'd0, 32'h0);
        #2;
        total_cnt++; if (regwrite !== 1'b0) $display("FAIL rst_regwrite: got %b want 0", regwrite); else pass_cnt++;
        total_cnt++; if (add_rd !== 5'd0) $display("FAIL rst_add_rd: got %0d want 0", add_rd); else pass_cnt++;
        total_cnt++; if (write_data !== 32'h0) $display("FAIL rst_write_data: got %h want 0", write_data); else pass_cnt++;
        total_cnt++; if (alu_ready !== 1'b1) $display("FAIL rst_alu_ready: got %b want 1", alu_ready); else pass_cnt++;
        total_cnt++; if (lsu_ready !== 1'b1) $display("FAIL rst_lsu_ready: got %b want 1", lsu_ready); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alu_alone();
        drive_alu(1'b1, 5'd5, 32'hDEADBEEF);
        #1;
        total_cnt++; if (alu_ready !== 1'b1) $display("FAIL alu_alone_ready: got %b want 1", alu_ready); else pass_cnt++;
        tick();
        drive_alu(1'b0, 5'd0, 32'h0);
        total_cnt++; if (regwrite !== 1'b1) $display("FAIL alu_alone_we: got %b want 1", regwrite); else pass_cnt++;
        total_cnt++; if (add_rd !== 5'd5) $display("FAIL alu_alone_rd: got %0d want 5", add_rd); else pass_cnt++;
        total_cnt++; if (write_data !== 32'hDEADBEEF) $display("FAIL alu_alone_data: got %h want deadbeef", write_data); else pass_cnt++;
        tick();
        total_cnt++; if (regwrite !== 1'b0) $display("FAIL alu_alone_we_off: got %b want 0", regwrite); else pass_cnt++;
    endtask

    task automatic test_x0_drop();
        drive_alu(1'b1, 5'd0, 32'h1234);
        drive_lsu(1'b1, 5'd0, 32'h55);
        #1;
        total_cnt++; if (alu_ready !== 1'b1) $display("FAIL x0_alu_ready: got %b want 1", alu_ready); else pass_cnt++;
        total_cnt++; if (lsu_ready !== 1'b1) $display("FAIL x0_lsu_ready: got %b want 1", lsu_ready); else pass_cnt++;
        tick();
        drive_alu(1'b0, 5'd0, 32'h0);
        drive_lsu(1'b0, 5'd0, 32'h0);
        total_cnt++; if (regwrite !== 1'b0) $display("FAIL x0_we: got %b want 0", regwrite); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL x0_busy: got %b want 0", busy); else pass_cnt++;
        tick();
        total_cnt++; if (regwrite !== 1'b0) $display("FAIL x0_we_later: got %b want 0", regwrite); else pass_cnt++;
    endtask

    task automatic test_contention();
        drive_alu(1'b1, 5'd3, 32'h33);
        drive_lsu(1'b1, 5'd7, 32'hA5);
        tick();
        drive_alu(1'b0, 5'd0, 32'h0);
        drive_lsu(1'b0, 5'd0, 32'h0);
        total_cnt++; if (regwrite !== 1'b1 || add_rd !== 5'd3 || write_data !== 32'h33)
            $display("FAIL cont_alu_write: got we=%b rd=%0d data=%h want we=1 rd=3 data=33", regwrite, add_rd, write_data); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL cont_busy: got %b want 1", busy); else pass_cnt++;
        tick();
        total_cnt++; if (regwrite !== 1'b1 || add_rd !== 5'd7 || write_data !== 32'hA5)
            $display("FAIL cont_lsu_write: got we=%b rd=%0d data=%h want we=1 rd=7 data=a5", regwrite, add_rd, write_data); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL cont_busy_clear: got %b want 0", busy); else pass_cnt++;
        tick();
        total_cnt++; if (regwrite !== 1'b0) $display("FAIL cont_we_off: got %b want 0", regwrite); else pass_cnt++;
    endtask

    task automatic test_fifo_full();
        logic [4:0] exp_rd [8]  = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd10, 5'd11, 5'd12};
        logic [31:0] exp_d [8]  = '{32'h101, 32'h102, 32'h103, 32'h104, 32'h105, 32'hA0, 32'hA1, 32'hA2};
        logic exp_lrdy [8]      = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic exp_ardy [8]      = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            // ALU issues rd1..rd5 then holds rd6 while stalled; LSU offers rd10..rd12
            if (i < 5) drive_alu(1'b1, 5'(i + 1), 32'h101 + 32'(i));
            else       drive_alu(1'b1, 5'd6, 32'h106);
            if (i < 2)      drive_lsu(1'b1, 5'(10 + i), 32'hA0 + 32'(i));
            else if (i < 7) drive_lsu(1'b1, 5'd12, 32'hA2);
            else            drive_lsu(1'b0, 5'd0, 32'h0);
            #1;
            total_cnt++; if (lsu_ready !== exp_lrdy[i]) $display("FAIL full_lsu_ready[%0d]: got %b want %b", i, lsu_ready, exp_lrdy[i]); else pass_cnt++;
            total_cnt++; if (alu_ready !== exp_ardy[i]) $display("FAIL full_alu_ready[%0d]: got %b want %b", i, alu_ready, exp_ardy[i]); else pass_cnt++;
            tick();
            total_cnt++; if (regwrite !== 1'b1 || add_rd !== exp_rd[i] || write_data !== exp_d[i])
                $display("FAIL full_write[%0d]: got we=%b rd=%0d data=%h want we=1 rd=%0d data=%h",
                         i, regwrite, add_rd, write_data, exp_rd[i], exp_d[i]); else pass_cnt++;
        end
        drive_lsu(1'b0, 5'd0, 32'h0);
        #1;
        total_cnt++; if (alu_ready !== 1'b1) $display("FAIL full_alu_ready_back: got %b want 1", alu_ready); else pass_cnt++;
        tick();
        drive_alu(1'b0, 5'd0, 32'h0);
        total_cnt++; if (regwrite !== 1'b1 || add_rd !== 5'd6 || write_data !== 32'h106)
            $display("FAIL full_held_alu: got we=%b rd=%0d data=%h want we=1 rd=6 data=106", regwrite, add_rd, write_data); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL full_busy_end: got %b want 0", busy); else pass_cnt++;
        tick();
        total_cnt++; if (regwrite !== 1'b0) $display("FAIL full_we_off: got %b want 0", regwrite); else pass_cnt++;
    endtask

    task automatic test_starvation();
        drive_alu(1'b1, 5'd1, 32'h201);
        drive_lsu(1'b1, 5'd20, 32'hB0);
        tick();
        drive_lsu(1'b0, 5'd0, 32'h0);
        total_cnt++; if (add_rd !== 5'd1) $display("FAIL starve_first: got %0d want 1", add_rd); else pass_cnt++;
        for (int k = 2; k <= 5; k++) begin
            drive_alu(1'b1, 5'(k), 32'h200 + 32'(k));
            #1;
            total_cnt++; if (alu_ready !== 1'b1) $display("FAIL starve_ready[%0d]: got %b want 1", k, alu_ready); else pass_cnt++;
            tick();
            total_cnt++; if (regwrite !== 1'b1 || add_rd !== 5'(k))
                $display("FAIL starve_alu_write[%0d]: got we=%b rd=%0d want we=1 rd=%0d", k, regwrite, add_rd, k); else pass_cnt++;
        end
        drive_alu(1'b1, 5'd6, 32'h206);
        #1;
        total_cnt++; if (alu_ready !== 1'b0) $display("FAIL starve_drain_ready: got %b want 0", alu_ready); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL starve_drain_busy: got %b want 1", busy); else pass_cnt++;
        tick();
        total_cnt++; if (regwrite !== 1'b1 || add_rd !== 5'd20 || write_data !== 32'hB0)
            $display("FAIL starve_drain_write: got we=%b rd=%0d data=%h want we=1 rd=20 data=b0", regwrite, add_rd, write_data); else pass_cnt++;
        total_cnt++; if (alu_ready !== 1'b1) $display("FAIL starve_normal_ready: got %b want 1", alu_ready); else pass_cnt++;
        tick();
        drive_alu(1'b0, 5'd0, 32'h0);
        total_cnt++; if (regwrite !== 1'b1 || add_rd !== 5'd6 || write_data !== 32'h206)
            $display("FAIL starve_held_alu: got we=%b rd=%0d data=%h want we=1 rd=6 data=206", regwrite, add_rd, write_data); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL starve_busy_end: got %b want 0", busy); else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid_drain();
        drive_alu(1'b1, 5'd1, 32'h301);
        drive_lsu(1'b1, 5'd21, 32'hC1);
        tick();
        drive_alu(1'b1, 5'd2, 32'h302);
        drive_lsu(1'b1, 5'd22, 32'hC2);
        tick();
        drive_lsu(1'b0, 5'd0, 32'h0);
        for (int k = 3; k <= 5; k++) begin
            drive_alu(1'b1, 5'(k), 32'h300 + 32'(k));
            tick();
        end
        drive_alu(1'b0, 5'd0, 32'h0);
        total_cnt++; if (regwrite !== 1'b1 || add_rd !== 5'd5) $display("FAIL rmd_pre_write: got we=%b rd=%0d want we=1 rd=5", regwrite, add_rd); else pass_cnt++;
        total_cnt++; if (alu_ready !== 1'b0 || busy !== 1'b1) $display("FAIL rmd_in_drain: got alu_ready=%b busy=%b want 0 1", alu_ready, busy); else pass_cnt++;
        #1;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (regwrite !== 1'b0) $display("FAIL rmd_async_we: got %b want 0", regwrite); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rmd_async_busy: got %b want 0", busy); else pass_cnt++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            total_cnt++; if (regwrite !== 1'b0 || busy !== 1'b0)
                $display("FAIL rmd_stale[%0d]: got we=%b busy=%b want 0 0", k, regwrite, busy); else pass_cnt++;
        end
        total_cnt++; if (alu_ready !== 1'b1 || lsu_ready !== 1'b1)
            $display("FAIL rmd_ready_after: got alu=%b lsu=%b want 1 1", alu_ready, lsu_ready); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_alu_alone();
        test_x0_drop();
        test_contention();
        test_fifo_full();
        test_starvation();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
